// File: rtl/apb_slave_regfile_if.sv
// APB completer-side bus bundle for apb_slave_regfile.
//   psel, penable, pwrite  - select, access-phase flag, direction (1 = write)
//   paddr, pwdata          - byte address (local offset) and write data
//   prdata, pready, pslverr - read data, completion strobe, error response
// Modports: master drives the request, slave drives the response.
interface apb_slave_regfile_if #(
  parameter int unsigned WIDTH = 32
);
  logic             psel;
  logic             penable;
  logic             pwrite;
  logic [WIDTH-1:0] paddr;
  logic [WIDTH-1:0] pwdata;
  logic [WIDTH-1:0] prdata;
  logic             pready;
  logic             pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_slave_regfile.sv
// APB completer backed by a bank of DEPTH x WIDTH word registers, one instance per Pselx bit.
// Inserts WAIT_STATES wait cycles (Pready low) before each completion and flags misaligned or
// out-of-range accesses with Pslverr. Pready/Pslverr/Prdata are registered.
// Ports:
//   i_hclk    - clock, all state on the rising edge
//   i_hreset  - asynchronous, active-high reset
//   io_apb    - apb_slave_regfile_if.slave: psel/penable/pwrite/paddr/pwdata in,
//               prdata/pready/pslverr out
// Optional build macro APB_SLAVE_RO_ID_EN: register 0 becomes a read-only ID register
// (reads return 32'hA5B0_0001 sized to WIDTH, writes to it are rejected with Pslverr).
module apb_slave_regfile #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic                 i_hclk,
  input  logic                 i_hreset,
  apb_slave_regfile_if.slave   io_apb
);

  localparam int unsigned AW = $clog2(DEPTH);
  // Counter preload: counts down to zero over WAIT_STATES cycles in StWait.
  localparam logic [3:0] WaitLoad = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {StIdle, StSetup, StWait, StAccess} state_e;

  state_e           r_state;
  logic [3:0]       r_wait_cnt;
  logic [WIDTH-1:0] r_addr;
  logic [WIDTH-1:0] r_wdata;
  logic             r_write;
  logic [WIDTH-1:0] r_prdata;
  logic             r_pready;
  logic             r_pslverr;
  logic [WIDTH-1:0] r_mem [DEPTH];

  state_e           w_phase;
  state_e           w_state_d;
  logic [3:0]       w_cnt_d;
  logic             w_setup;
  logic [WIDTH-1:0] w_cur_addr;
  logic             w_cur_write;
  logic [AW-1:0]    w_idx;
  logic [AW-1:0]    w_wr_idx;
  logic             w_addr_err;
  logic             w_err;
  logic             w_we;
  logic [WIDTH-1:0] w_rd_data;
  logic             w_pready_d;
  logic             w_pslverr_d;
  logic [WIDTH-1:0] w_prdata_d;

  // The setup phase is recognised in the very cycle the master presents it, so the registered
  // state only holds Idle/Wait/Access. Access always returns to Idle, and a new setup is taken
  // from Idle in the same cycle, so back-to-back transfers need no gap cycle.
  assign w_setup = io_apb.psel && !io_apb.penable && (r_state == StIdle);
  assign w_phase = w_setup ? StSetup : r_state;

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_wait_cnt;
    unique case (w_phase)
      StIdle: w_state_d = StIdle;
      StSetup: begin
        if (WAIT_STATES > 0) begin
          w_state_d = StWait;
          w_cnt_d   = WaitLoad;
        end else begin
          w_state_d = StAccess;
        end
      end
      StWait: begin
        if (!io_apb.psel) begin
          w_state_d = StIdle;  // aborted by the master, nothing is committed
        end else if (r_wait_cnt == 4'd0) begin
          w_state_d = StAccess;
        end else begin
          w_cnt_d = r_wait_cnt - 4'd1;
        end
      end
      StAccess: w_state_d = StIdle;
      default:  w_state_d = StIdle;
    endcase
  end

  // Decode the transfer that is about to enter Access: straight off the bus when there are no
  // wait states (setup -> access in one edge), otherwise from the setup-time latches.
  assign w_cur_addr  = w_setup ? io_apb.paddr  : r_addr;
  assign w_cur_write = w_setup ? io_apb.pwrite : r_write;
  assign w_idx       = w_cur_addr[AW+1:2];
  assign w_addr_err  = (w_cur_addr[1:0] != 2'b00) || ((w_cur_addr >> (AW + 2)) != '0);

`ifdef APB_SLAVE_RO_ID_EN
  localparam logic [31:0] IdValue = 32'hA5B0_0001;
  assign w_err     = w_addr_err || (w_cur_write && (w_idx == '0));
  assign w_rd_data = (w_idx == '0) ? WIDTH'(IdValue) : r_mem[w_idx];
`else
  assign w_err     = w_addr_err;
  assign w_rd_data = r_mem[w_idx];
`endif

  always_comb begin
    w_pready_d  = (w_state_d == StAccess);
    w_pslverr_d = w_pready_d && w_err;
    w_prdata_d  = '0;
    if (w_pready_d && !w_err && !w_cur_write) begin
      w_prdata_d = w_rd_data;
    end
  end

  // Commit on the edge that ends the Pready cycle; Pslverr already holds the error verdict.
  assign w_we     = (r_state == StAccess) && r_write && !r_pslverr;
  assign w_wr_idx = r_addr[AW+1:2];

  always_ff @(posedge i_hclk or posedge i_hreset) begin
    if (i_hreset) begin
      r_state    <= StIdle;
      r_wait_cnt <= 4'd0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_write    <= 1'b0;
      r_prdata   <= '0;
      r_pready   <= 1'b0;
      r_pslverr  <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_wait_cnt <= w_cnt_d;
      r_prdata   <= w_prdata_d;
      r_pready   <= w_pready_d;
      r_pslverr  <= w_pslverr_d;
      if (w_setup) begin
        r_addr  <= io_apb.paddr;
        r_wdata <= io_apb.pwdata;
        r_write <= io_apb.pwrite;
      end
    end
  end

  always_ff @(posedge i_hclk or posedge i_hreset) begin
    if (i_hreset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_we) begin
      r_mem[w_wr_idx] <= r_wdata;
    end
  end

  assign io_apb.prdata  = r_prdata;
  assign io_apb.pready  = r_pready;
  assign io_apb.pslverr = r_pslverr;

endmodule
